// File: rtl/esfa_op_sequencer_pkg.sv
// Shared types for the ESFA operation sequencer.
//   op_e    : request opcodes (6-7 are reserved and never stored)
//   state_e : sequencer FSM states
package esfa_op_sequencer_pkg;

  typedef enum logic [2:0] {
    OP_NOP          = 3'd0,
    OP_UPDATE       = 3'd1,
    OP_LOOKUP       = 3'd2,
    OP_DELETE       = 3'd3,
    OP_CONGRUE_UP   = 3'd4,
    OP_CONGRUE_DOWN = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_APPLY = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  // Reserved opcodes are answered immediately with ok=0.
  function automatic logic op_is_defined(input logic [2:0] op);
    return (op <= 3'd5);
  endfunction

endpackage

// File: rtl/esfa_op_sequencer_if.sv
// Request/response bus of the ESFA operation sequencer.
//   master : host side (drives req_*, observes ready/resp/occupancy)
//   slave  : sequencer side
interface esfa_op_sequencer_if #(
  parameter int unsigned IDX_W = 8,
  parameter int unsigned VAL_W = 16,
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [IDX_W-1:0] req_index;
  logic [VAL_W-1:0] req_value;
  logic             req_is_handle;
  logic             resp_valid;
  logic             resp_ok;
  logic [VAL_W-1:0] resp_value;
  logic [OCC_W-1:0] occupancy;

  modport master (
    output req_valid, req_op, req_index, req_value, req_is_handle,
    input  req_ready, resp_valid, resp_ok, resp_value, occupancy
  );

  modport slave (
    input  req_valid, req_op, req_index, req_value, req_is_handle,
    output req_ready, resp_valid, resp_ok, resp_value, occupancy
  );
endinterface

// File: rtl/esfa_op_sequencer_cell_array.sv
// DEPTH tuple cells {valid, is_handle, index, value}.
//   i_clk/i_rst_n : clock, async active-low clear of every cell
//   i_raddr, o_r* : combinational read port
//   i_we, i_waddr, i_w* : single synchronous write port
module esfa_op_sequencer_cell_array #(
  parameter int unsigned IDX_W = 8,
  parameter int unsigned VAL_W = 16,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [PTR_W-1:0] i_raddr,
  output logic             o_rvalid,
  output logic             o_rhandle,
  output logic [IDX_W-1:0] o_rindex,
  output logic [VAL_W-1:0] o_rvalue,
  input  logic             i_we,
  input  logic [PTR_W-1:0] i_waddr,
  input  logic             i_wvalid,
  input  logic             i_whandle,
  input  logic [IDX_W-1:0] i_windex,
  input  logic [VAL_W-1:0] i_wvalue
);

  typedef struct packed {
    logic             valid;
    logic             is_handle;
    logic [IDX_W-1:0] index;
    logic [VAL_W-1:0] value;
  } cell_t;

  cell_t r_cells [DEPTH];
  cell_t w_rd;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_cells[i] <= '0;
      end
    end else if (i_we) begin
      r_cells[i_waddr] <= '{valid: i_wvalid, is_handle: i_whandle,
                            index: i_windex, value: i_wvalue};
    end
  end

  always_comb begin
    w_rd = r_cells[i_raddr];
  end

  assign o_rvalid  = w_rd.valid;
  assign o_rhandle = w_rd.is_handle;
  assign o_rindex  = w_rd.index;
  assign o_rvalue  = w_rd.value;

endmodule

// File: rtl/esfa_op_sequencer.sv
// ESFA operation sequencer: accepts one opcode per req_valid/req_ready
// transfer, scans the cell array one cell per cycle, applies the result
// and emits a single-cycle resp_valid pulse.
//   clk, rst_n : clock, async active-low reset
//   bus        : esfa_op_sequencer_if.slave (request, response, occupancy)
module esfa_op_sequencer
  import esfa_op_sequencer_pkg::*;
#(
  parameter int unsigned IDX_W = 8,
  parameter int unsigned VAL_W = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  esfa_op_sequencer_if.slave  bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

  state_e           r_state,      w_state_nxt;
  op_e              r_op,         w_op_nxt;
  logic [IDX_W-1:0] r_index,      w_index_nxt;
  logic [VAL_W-1:0] r_value,      w_value_nxt;
  logic             r_is_handle,  w_is_handle_nxt;
  logic [PTR_W-1:0] r_ptr,        w_ptr_nxt;
  logic             r_hit,        w_hit_nxt;
  logic [PTR_W-1:0] r_hit_ptr,    w_hit_ptr_nxt;
  logic             r_free,       w_free_nxt;
  logic [PTR_W-1:0] r_free_ptr,   w_free_ptr_nxt;
  logic [OCC_W-1:0] r_cnt,        w_cnt_nxt;
  logic             r_ovf,        w_ovf_nxt;
  logic [OCC_W-1:0] r_occ,        w_occ_nxt;
  logic             r_resp_ok,    w_resp_ok_nxt;
  logic [VAL_W-1:0] r_resp_value, w_resp_value_nxt;

  logic [PTR_W-1:0] w_raddr;
  logic             w_rvalid, w_rhandle;
  logic [IDX_W-1:0] w_rindex;
  logic [VAL_W-1:0] w_rvalue;
  logic             w_we, w_wvalid, w_whandle;
  logic [PTR_W-1:0] w_waddr;
  logic [IDX_W-1:0] w_windex;
  logic [VAL_W-1:0] w_wvalue;
  logic             w_match, w_last;

  esfa_op_sequencer_cell_array #(
    .IDX_W (IDX_W),
    .VAL_W (VAL_W),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_cells (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_raddr   (w_raddr),
    .o_rvalid  (w_rvalid),
    .o_rhandle (w_rhandle),
    .o_rindex  (w_rindex),
    .o_rvalue  (w_rvalue),
    .i_we      (w_we),
    .i_waddr   (w_waddr),
    .i_wvalid  (w_wvalid),
    .i_whandle (w_whandle),
    .i_windex  (w_windex),
    .i_wvalue  (w_wvalue)
  );

  // APPLY re-reads the matched cell (LOOKUP/DELETE need its value).
  assign w_raddr = (r_state == S_APPLY) ? r_hit_ptr : r_ptr;
  assign w_match = w_rvalid && (w_rindex == r_index);
  assign w_last  = (r_ptr == LAST_PTR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_op         <= OP_NOP;
      r_index      <= '0;
      r_value      <= '0;
      r_is_handle  <= 1'b0;
      r_ptr        <= '0;
      r_hit        <= 1'b0;
      r_hit_ptr    <= '0;
      r_free       <= 1'b0;
      r_free_ptr   <= '0;
      r_cnt        <= '0;
      r_ovf        <= 1'b0;
      r_occ        <= '0;
      r_resp_ok    <= 1'b0;
      r_resp_value <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_op         <= w_op_nxt;
      r_index      <= w_index_nxt;
      r_value      <= w_value_nxt;
      r_is_handle  <= w_is_handle_nxt;
      r_ptr        <= w_ptr_nxt;
      r_hit        <= w_hit_nxt;
      r_hit_ptr    <= w_hit_ptr_nxt;
      r_free       <= w_free_nxt;
      r_free_ptr   <= w_free_ptr_nxt;
      r_cnt        <= w_cnt_nxt;
      r_ovf        <= w_ovf_nxt;
      r_occ        <= w_occ_nxt;
      r_resp_ok    <= w_resp_ok_nxt;
      r_resp_value <= w_resp_value_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_op_nxt         = r_op;
    w_index_nxt      = r_index;
    w_value_nxt      = r_value;
    w_is_handle_nxt  = r_is_handle;
    w_ptr_nxt        = r_ptr;
    w_hit_nxt        = r_hit;
    w_hit_ptr_nxt    = r_hit_ptr;
    w_free_nxt       = r_free;
    w_free_ptr_nxt   = r_free_ptr;
    w_cnt_nxt        = r_cnt;
    w_ovf_nxt        = r_ovf;
    w_occ_nxt        = r_occ;
    w_resp_ok_nxt    = r_resp_ok;
    w_resp_value_nxt = r_resp_value;
    w_we             = 1'b0;
    w_waddr          = r_ptr;
    w_wvalid         = w_rvalid;
    w_whandle        = w_rhandle;
    w_windex         = w_rindex;
    w_wvalue         = w_rvalue;

    unique case (r_state)
      S_IDLE: begin
        if (bus.req_valid) begin
          w_index_nxt     = bus.req_index;
          w_value_nxt     = bus.req_value;
          w_is_handle_nxt = bus.req_is_handle;
          w_ptr_nxt       = '0;
          w_hit_nxt       = 1'b0;
          w_free_nxt      = 1'b0;
          w_cnt_nxt       = '0;
          w_ovf_nxt       = 1'b0;
          if (!op_is_defined(bus.req_op)) begin
            w_op_nxt         = OP_NOP;
            w_resp_ok_nxt    = 1'b0;
            w_resp_value_nxt = '0;
            w_state_nxt      = S_RESP;
          end else if (op_e'(bus.req_op) == OP_NOP) begin
            w_op_nxt         = OP_NOP;
            w_resp_ok_nxt    = 1'b1;
            w_resp_value_nxt = '0;
            w_state_nxt      = S_RESP;
          end else begin
            w_op_nxt    = op_e'(bus.req_op);
            w_state_nxt = S_SCAN;
          end
        end
      end

      S_SCAN: begin
        case (r_op)
          OP_UPDATE, OP_LOOKUP, OP_DELETE: begin
            if (!w_rvalid && !r_free) begin
              w_free_nxt     = 1'b1;
              w_free_ptr_nxt = r_ptr;
            end
            if (w_match) begin
              w_hit_nxt     = 1'b1;
              w_hit_ptr_nxt = r_ptr;
              w_state_nxt   = S_APPLY;
            end else if (w_last) begin
              w_state_nxt = S_APPLY;
            end else begin
              w_ptr_nxt = r_ptr + 1'b1;
            end
          end
          OP_CONGRUE_UP: begin
            // A cell already at all-ones would wrap; leave it and flag it.
            if (w_rvalid && (w_rindex >= r_index)) begin
              if (w_rindex == '1) begin
                w_ovf_nxt = 1'b1;
              end else begin
                w_we      = 1'b1;
                w_windex  = w_rindex + 1'b1;
                w_cnt_nxt = r_cnt + 1'b1;
              end
            end
            if (w_last) w_state_nxt = S_APPLY;
            else        w_ptr_nxt   = r_ptr + 1'b1;
          end
          OP_CONGRUE_DOWN: begin
            // The pivot cell is removed; only cells strictly above it
            // decrement, so no index ever drops below req_index.
            if (w_match) begin
              w_we      = 1'b1;
              w_wvalid  = 1'b0;
              w_whandle = 1'b0;
              w_windex  = '0;
              w_wvalue  = '0;
              w_cnt_nxt = r_cnt + 1'b1;
              if (r_occ != '0) w_occ_nxt = r_occ - 1'b1;
            end else if (w_rvalid && (w_rindex > r_index)) begin
              w_we      = 1'b1;
              w_windex  = w_rindex - 1'b1;
              w_cnt_nxt = r_cnt + 1'b1;
            end
            if (w_last) w_state_nxt = S_APPLY;
            else        w_ptr_nxt   = r_ptr + 1'b1;
          end
          default: w_state_nxt = S_APPLY;
        endcase
      end

      S_APPLY: begin
        w_state_nxt = S_RESP;
        case (r_op)
          OP_UPDATE: begin
            w_resp_value_nxt = r_value;
            w_wvalid         = 1'b1;
            w_whandle        = r_is_handle;
            w_windex         = r_index;
            w_wvalue         = r_value;
            if (r_hit) begin
              w_we          = 1'b1;
              w_waddr       = r_hit_ptr;
              w_resp_ok_nxt = 1'b1;
            end else if (r_free && (r_occ != FULL_OCC)) begin
              w_we          = 1'b1;
              w_waddr       = r_free_ptr;
              w_occ_nxt     = r_occ + 1'b1;
              w_resp_ok_nxt = 1'b1;
            end else begin
              w_resp_ok_nxt = 1'b0;
            end
          end
          OP_LOOKUP: begin
            w_resp_ok_nxt    = r_hit;
            w_resp_value_nxt = r_hit ? w_rvalue : '0;
          end
          OP_DELETE: begin
            if (r_hit) begin
              w_we             = 1'b1;
              w_waddr          = r_hit_ptr;
              w_wvalid         = 1'b0;
              w_whandle        = 1'b0;
              w_windex         = '0;
              w_wvalue         = '0;
              if (r_occ != '0) w_occ_nxt = r_occ - 1'b1;
              w_resp_ok_nxt    = 1'b1;
              w_resp_value_nxt = w_rvalue;
            end else begin
              w_resp_ok_nxt    = 1'b0;
              w_resp_value_nxt = '0;
            end
          end
          OP_CONGRUE_UP, OP_CONGRUE_DOWN: begin
            w_resp_ok_nxt    = !r_ovf;
            w_resp_value_nxt = VAL_W'(r_cnt);
          end
          default: begin
            w_resp_ok_nxt    = 1'b0;
            w_resp_value_nxt = '0;
          end
        endcase
      end

      S_RESP: w_state_nxt = S_IDLE;

      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.req_ready  = (r_state == S_IDLE);
  assign bus.resp_valid = (r_state == S_RESP);
  assign bus.resp_ok    = r_resp_ok;
  assign bus.resp_value = r_resp_value;
  assign bus.occupancy  = r_occ;

endmodule

// File: tb/tb_esfa_op_sequencer.sv
// Directed bench for esfa_op_sequencer (DEPTH=8, IDX_W=8, VAL_W=16).
// Latency is counted in cycles after the accepting edge: k scanned cells
// give resp_valid in cycle k+2, NOP/reserved in cycle 1.
module tb_esfa_op_sequencer;

  localparam int unsigned IDX_W = 8;
  localparam int unsigned VAL_W = 16;
  localparam int unsigned DEPTH = 8;
  localparam int          FULL  = DEPTH + 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  esfa_op_sequencer_if #(.IDX_W(IDX_W), .VAL_W(VAL_W), .DEPTH(DEPTH)) bus ();

  esfa_op_sequencer #(.IDX_W(IDX_W), .VAL_W(VAL_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_acc = 0;
  int n_resp = 0;

  logic             got_ok;
  logic [VAL_W-1:0] got_val;
  int               got_lat;
  int               a0, r0;

  always @(negedge clk) begin
    if (bus.req_valid && bus.req_ready) n_acc++;
    if (bus.resp_valid) n_resp++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [IDX_W-1:0] idx,
                        input logic [VAL_W-1:0] val, input logic hdl);
    bus.req_op        = op;
    bus.req_index     = idx;
    bus.req_value     = val;
    bus.req_is_handle = hdl;
    bus.req_valid     = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    got_lat = 1;
    while (bus.resp_valid !== 1'b1 && got_lat < 40) begin
      @(posedge clk);
      #1 got_lat++;
    end
    got_ok  = bus.resp_ok;
    got_val = bus.resp_value;
    @(posedge clk);
    #1;
  endtask

  task automatic check_op(input string tag, input logic eok,
                          input logic [VAL_W-1:0] eval, input int elat);
    chk({tag, "_ok"},  32'(got_ok),  32'(eok));
    chk({tag, "_val"}, 32'(got_val), 32'(eval));
    chk({tag, "_lat"}, 32'(got_lat), 32'(elat));
  endtask

  initial begin
    bus.req_valid     = 1'b0;
    bus.req_op        = 3'd0;
    bus.req_index     = '0;
    bus.req_value     = '0;
    bus.req_is_handle = 1'b0;
    #2;
    do_reset();
    #1;
    chk("rst_ready", 32'(bus.req_ready),  32'd1);
    chk("rst_rv",    32'(bus.resp_valid), 32'd0);
    chk("rst_ok",    32'(bus.resp_ok),    32'd0);
    chk("rst_val",   32'(bus.resp_value), 32'd0);
    chk("rst_occ",   32'(bus.occupancy),  32'd0);

    // Insert and look up
    run_op(3'd1, 8'd5, 16'h1234, 1'b0); check_op("upd5", 1'b1, 16'h1234, FULL);
    chk("occ_1", 32'(bus.occupancy), 32'd1);
    run_op(3'd2, 8'd5, 16'h0, 1'b0);    check_op("lkp5", 1'b1, 16'h1234, 3);
    run_op(3'd2, 8'd9, 16'h0, 1'b0);    check_op("lkp9", 1'b0, 16'h0, FULL);

    // Fill the store (indices 10..16 land in cells 1..7)
    for (int i = 10; i <= 16; i++) run_op(3'd1, 8'(i), 16'(16'h0100 + i), 1'b1);
    chk("occ_full", 32'(bus.occupancy), 32'd8);
    run_op(3'd1, 8'd20, 16'hBEEF, 1'b0); check_op("upd_full", 1'b0, 16'hBEEF, FULL);
    chk("occ_full2", 32'(bus.occupancy), 32'd8);
    run_op(3'd1, 8'd12, 16'h5555, 1'b0); check_op("upd_exist", 1'b1, 16'h5555, 6);
    chk("occ_nogrow", 32'(bus.occupancy), 32'd8);
    run_op(3'd2, 8'd12, 16'h0, 1'b0);    check_op("lkp12", 1'b1, 16'h5555, 6);

    // Delete, then update across the hole without duplicating
    run_op(3'd3, 8'd5, 16'h0, 1'b0);     check_op("del5", 1'b1, 16'h1234, 3);
    chk("occ_del", 32'(bus.occupancy), 32'd7);
    run_op(3'd3, 8'd5, 16'h0, 1'b0);     check_op("del5_miss", 1'b0, 16'h0, FULL);
    run_op(3'd1, 8'd16, 16'h6666, 1'b0); check_op("upd_hole", 1'b1, 16'h6666, FULL);
    chk("occ_nodup", 32'(bus.occupancy), 32'd7);
    run_op(3'd2, 8'd16, 16'h0, 1'b0);    check_op("lkp16", 1'b1, 16'h6666, FULL);
    run_op(3'd1, 8'd30, 16'h3030, 1'b0); check_op("upd_alloc", 1'b1, 16'h3030, FULL);
    run_op(3'd2, 8'd30, 16'h0, 1'b0);    check_op("lkp30", 1'b1, 16'h3030, 3);
    chk("occ_refill", 32'(bus.occupancy), 32'd8);

    // Congruence shifts on {2,5,7}
    do_reset();
    run_op(3'd1, 8'd2, 16'h0002, 1'b0);
    run_op(3'd1, 8'd5, 16'h0005, 1'b0);
    run_op(3'd1, 8'd7, 16'h0007, 1'b0);
    run_op(3'd4, 8'd5, 16'h0, 1'b0);     check_op("cup5", 1'b1, 16'd2, FULL);
    run_op(3'd2, 8'd6, 16'h0, 1'b0);     check_op("cup_l6", 1'b1, 16'h0005, 4);
    run_op(3'd2, 8'd8, 16'h0, 1'b0);     check_op("cup_l8", 1'b1, 16'h0007, 5);
    run_op(3'd2, 8'd5, 16'h0, 1'b0);     check_op("cup_l5", 1'b0, 16'h0, FULL);
    run_op(3'd2, 8'd2, 16'h0, 1'b0);     check_op("cup_l2", 1'b1, 16'h0002, 3);
    run_op(3'd5, 8'd6, 16'h0, 1'b0);     check_op("cdn6", 1'b1, 16'd2, FULL);
    chk("occ_cdn", 32'(bus.occupancy), 32'd2);
    run_op(3'd2, 8'd7, 16'h0, 1'b0);     check_op("cdn_l7", 1'b1, 16'h0007, 5);
    run_op(3'd2, 8'd6, 16'h0, 1'b0);     check_op("cdn_l6", 1'b0, 16'h0, FULL);

    // Saturation at all-ones, sticky flag cleared by the next op
    do_reset();
    run_op(3'd1, 8'hFF, 16'hAAAA, 1'b0);
    run_op(3'd4, 8'h00, 16'h0, 1'b0);    check_op("cup_ovf", 1'b0, 16'd0, FULL);
    run_op(3'd2, 8'hFF, 16'h0, 1'b0);    check_op("ovf_lff", 1'b1, 16'hAAAA, 3);
    run_op(3'd1, 8'h10, 16'h0BB0, 1'b0);
    run_op(3'd5, 8'h10, 16'h0, 1'b0);    check_op("cdn10", 1'b1, 16'd2, FULL);
    chk("occ_cdn10", 32'(bus.occupancy), 32'd1);
    run_op(3'd2, 8'hFE, 16'h0, 1'b0);    check_op("cdn_lfe", 1'b1, 16'hAAAA, 3);
    run_op(3'd0, 8'h00, 16'h0, 1'b0);    check_op("nop", 1'b1, 16'h0, 1);
    run_op(3'd7, 8'h00, 16'h0, 1'b0);    check_op("rsvd", 1'b0, 16'h0, 1);

    // Reset in the middle of a scan drops the operation
    run_op(3'd1, 8'h01, 16'h1111, 1'b0);
    bus.req_op = 3'd2; bus.req_index = 8'h77; bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    r0 = n_resp;
    #1;
    chk("mid_ready", 32'(bus.req_ready),  32'd1);
    chk("mid_rv",    32'(bus.resp_valid), 32'd0);
    chk("mid_occ",   32'(bus.occupancy),  32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("mid_noresp", 32'(n_resp - r0), 32'd0);

    // req_valid held while busy: exactly one transfer, one response
    a0 = n_acc;
    r0 = n_resp;
    bus.req_op = 3'd2; bus.req_index = 8'h03; bus.req_valid = 1'b1;
    repeat (6) @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("hold_acc",  32'(n_acc - a0),  32'd1);
    chk("hold_resp", 32'(n_resp - r0), 32'd1);
    chk("hold_ok",   32'(bus.resp_ok), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
